sdram_arbiter: RTL and testbench

//   Central SDRAM command scheduler between sdram_init, sdram_ref, sdram_write and sdram_read.
//   - Tracks the controller phase and grants the shared SDRAM command/address/bank/DQ bus to one sub-controller at a time.
//   - Muxes each sub-controller's command and address onto the pins.
//   - Adds a per-grant watchdog so a hung sub-controller cannot lock the bus.

---
 rtl/sdram_arbiter.sv | 149 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// SDRAM command scheduler: grants the shared command/address/DQ bus to init, refresh,
// write or read with a per-grant watchdog. Define SDRAM_ARB_RR_EN for round-robin write/read ties.
module sdram_arbiter #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  input  logic        flag_init_end,
  input  logic        ref_req,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic        flag_ref_end,
  input  logic        flag_wr_end,
  input  logic        flag_rd_end,
  input  logic [3:0]  init_cmd,
  input  logic [3:0]  ref_cmd,
  input  logic [3:0]  wr_cmd,
  input  logic [3:0]  rd_cmd,
  input  logic [12:0] init_addr,
  input  logic [12:0] ref_addr,
  input  logic [12:0] wr_addr,
  input  logic [12:0] rd_addr,
  input  logic [1:0]  wr_bank,
  input  logic [1:0]  rd_bank,
  output logic        ref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic [4:0]  state,
  output logic [3:0]  sd_cmd,
  output logic [12:0] sd_addr,
  output logic [1:0]  sd_bank,
  output logic        dq_oe,
  output logic        err_timeout,
  output logic        busy
);

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    ARBIT = 5'b00010,
    AREF  = 5'b00100,
    WRITE = 5'b01000,
    READ  = 5'b10000
  } state_e;

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam logic [3:0]       NOP    = 4'b0111;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wr_win;
  logic             rd_win;
  logic             owner_end;

`ifdef SDRAM_ARB_RR_EN
  // 1 = last data grant was a write; reset value points at read so the first tie goes to write.
  logic last_wr_q;

  always_comb begin
    wr_win = wr_req & (~rd_req | ~last_wr_q);
    rd_win = rd_req & ~wr_win;
  end
`else
  always_comb begin
    wr_win = wr_req;
    rd_win = rd_req & ~wr_req;
  end
`endif

  always_comb begin
    owner_end = ((state_q == AREF)  & flag_ref_end) |
                ((state_q == WRITE) & flag_wr_end)  |
                ((state_q == READ)  & flag_rd_end);
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ref_en      <= 1'b0;
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      err_timeout <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
      last_wr_q   <= 1'b0;
`endif
    end else begin
      ref_en      <= 1'b0;
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      err_timeout <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flag_init_end) state_q <= ARBIT;
        end
        ARBIT: begin
          cnt_q <= '0;
          if (ref_req) begin
            state_q <= AREF;
            ref_en  <= 1'b1;
          end else if (wr_win) begin
            state_q <= WRITE;
            wr_en   <= 1'b1;
`ifdef SDRAM_ARB_RR_EN
            last_wr_q <= 1'b1;
`endif
          end else if (rd_win) begin
            state_q <= READ;
            rd_en   <= 1'b1;
`ifdef SDRAM_ARB_RR_EN
            last_wr_q <= 1'b0;
`endif
          end
        end
        AREF, WRITE, READ: begin
          // A real end flag beats a simultaneous watchdog expiry.
          if (owner_end) begin
            state_q <= ARBIT;
          end else if (cnt_q == TO_VAL) begin
            state_q     <= ARBIT;
            err_timeout <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pin decode depends on registered state only, so request edges never glitch the bus.
  always_comb begin
    sd_cmd  = NOP;
    sd_addr = '0;
    case (state_q)
      IDLE:  begin sd_cmd = init_cmd; sd_addr = init_addr; end
      AREF:  begin sd_cmd = ref_cmd;  sd_addr = ref_addr;  end
      WRITE: begin sd_cmd = wr_cmd;   sd_addr = wr_addr;   end
      READ:  begin sd_cmd = rd_cmd;   sd_addr = rd_addr;   end
      default: begin sd_cmd = NOP; sd_addr = '0; end
    endcase
  end

  assign state   = state_q;
  assign sd_bank = (state_q == WRITE) ? wr_bank : rd_bank;
  assign dq_oe   = (state_q == WRITE);
  assign busy    = (state_q == AREF) | (state_q == WRITE) | (state_q == READ);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter (TIMEOUT=16): init, priority, tie policy, watchdog, async reset.
module tb_sdram_arbiter;

  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_ARBIT = 5'b00010;
  localparam logic [4:0] S_AREF  = 5'b00100;
  localparam logic [4:0] S_WRITE = 5'b01000;
  localparam logic [4:0] S_READ  = 5'b10000;

  logic        sclk;
  logic        s_rst_n;
  logic        flag_init_end, ref_req, wr_req, rd_req;
  logic        flag_ref_end, flag_wr_end, flag_rd_end;
  logic [3:0]  init_cmd, ref_cmd, wr_cmd, rd_cmd;
  logic [12:0] init_addr, ref_addr, wr_addr, rd_addr;
  logic [1:0]  wr_bank, rd_bank;
  logic        ref_en, wr_en, rd_en;
  logic [4:0]  state;
  logic [3:0]  sd_cmd;
  logic [12:0] sd_addr;
  logic [1:0]  sd_bank;
  logic        dq_oe, err_timeout, busy;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];
  logic [4:0] cur_owner;
  logic [4:0] nxt_owner;

  sdram_arbiter #(.TIMEOUT(16), .CNT_W(10)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .flag_init_end(flag_init_end),
    .ref_req(ref_req), .wr_req(wr_req), .rd_req(rd_req),
    .flag_ref_end(flag_ref_end), .flag_wr_end(flag_wr_end), .flag_rd_end(flag_rd_end),
    .init_cmd(init_cmd), .ref_cmd(ref_cmd), .wr_cmd(wr_cmd), .rd_cmd(rd_cmd),
    .init_addr(init_addr), .ref_addr(ref_addr), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .wr_bank(wr_bank), .rd_bank(rd_bank),
    .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en), .state(state),
    .sd_cmd(sd_cmd), .sd_addr(sd_addr), .sd_bank(sd_bank),
    .dq_oe(dq_oe), .err_timeout(err_timeout), .busy(busy)
  );

  // clock / reset
  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one edge, then sit 1ns after it for driving and sampling
  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic [4:0] exp_state);
    check({tag, "_state"}, state, exp_state);
    check({tag, "_wr_en"}, wr_en, exp_state == S_WRITE);
    check({tag, "_rd_en"}, rd_en, exp_state == S_READ);
  endtask

  task automatic pulse_end(input logic [4:0] owner);
    flag_ref_end = (owner == S_AREF);
    flag_wr_end  = (owner == S_WRITE);
    flag_rd_end  = (owner == S_READ);
    step();
    flag_ref_end = 1'b0;
    flag_wr_end  = 1'b0;
    flag_rd_end  = 1'b0;
  endtask

  initial begin
    s_rst_n = 1'b0; flag_init_end = 1'b0;
    ref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    flag_ref_end = 1'b0; flag_wr_end = 1'b0; flag_rd_end = 1'b0;
    init_cmd = 4'hA; ref_cmd = 4'h1; wr_cmd = 4'h4; rd_cmd = 4'h5;
    init_addr = 13'h123; ref_addr = 13'h0AA; wr_addr = 13'h1B0; rd_addr = 13'h0C5;
    wr_bank = 2'b10; rd_bank = 2'b01;

    // 1. reset and init
    repeat (3) step();
    check("rst_state", state, S_IDLE);
    check("rst_en", {ref_en, wr_en, rd_en}, 3'b000);
    check("rst_err", err_timeout, 1'b0);
    check("idle_cmd", sd_cmd, 4'hA);
    check("idle_addr", sd_addr, 13'h123);
    check("idle_dq_oe", dq_oe, 1'b0);
    check("idle_bank", sd_bank, 2'b01);
    s_rst_n = 1'b1;
    wr_req = 1'b1; ref_req = 1'b1;
    repeat (16) step();
    check("idle_ignores_req", state, S_IDLE);
    check("idle_no_en", {ref_en, wr_en, rd_en}, 3'b000);
    wr_req = 1'b0; ref_req = 1'b0;
    flag_init_end = 1'b1;
    step();
    check("init_to_arbit", state, S_ARBIT);
    check("arbit_nop", sd_cmd, 4'b0111);
    check("arbit_addr", sd_addr, 13'h0);
    repeat (3) step();
    check("arbit_hold", state, S_ARBIT);
    check("arbit_busy", busy, 1'b0);

    // 2. refresh beats data; other requests held off during the grant
    ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    step();
    check("aref_state", state, S_AREF);
    check("aref_en", {ref_en, wr_en, rd_en}, 3'b100);
    check("aref_cmd", sd_cmd, 4'h1);
    check("aref_addr", sd_addr, 13'h0AA);
    check("aref_busy", busy, 1'b1);
    ref_req = 1'b0;
    step();
    check("aref_en_pulse", ref_en, 1'b0);
    check("aref_held", state, S_AREF);
    pulse_end(S_WRITE);
    check("foreign_end_ignored", state, S_AREF);
    pulse_end(S_AREF);
    check("aref_end_arbit", state, S_ARBIT);
    check("gap_no_en", {ref_en, wr_en, rd_en}, 3'b000);
    step();
    check_grant("first_data", S_WRITE);
    check("write_cmd", sd_cmd, 4'h4);
    check("write_addr", sd_addr, 13'h1B0);
    check("write_bank", sd_bank, 2'b10);
    check("write_dq_oe", dq_oe, 1'b1);

    // 3. tie policy with both data requests held
`ifdef SDRAM_ARB_RR_EN
    exp_q.push_back(S_READ); exp_q.push_back(S_WRITE); exp_q.push_back(S_READ);
`else
    exp_q.push_back(S_WRITE); exp_q.push_back(S_WRITE); exp_q.push_back(S_WRITE);
`endif
    cur_owner = S_WRITE;
    while (exp_q.size() > 0) begin
      repeat (7) step();
      check("burst_held", state, cur_owner);
      pulse_end(cur_owner);
      check("burst_end_arbit", state, S_ARBIT);
      step();
      nxt_owner = exp_q.pop_front();
      check_grant("tie_grant", nxt_owner);
      cur_owner = nxt_owner;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    pulse_end(cur_owner);
    check("tie_done_arbit", state, S_ARBIT);
    step();
    check("idle_arbit", state, S_ARBIT);

    // 4. watchdog expiry on a hung write
    wr_req = 1'b1;
    step();
    check_grant("wd_grant", S_WRITE);
    wr_req = 1'b0;
    repeat (16) step();
    check("wd_17th_cycle", state, S_WRITE);
    check("wd_no_err_yet", err_timeout, 1'b0);
    step();
    check("wd_to_arbit", state, S_ARBIT);
    check("wd_err", err_timeout, 1'b1);
    check("wd_dq_oe", dq_oe, 1'b0);
    step();
    check("wd_err_pulse", err_timeout, 1'b0);

    // 5. end flag coinciding with expiry wins
    rd_req = 1'b1;
    step();
    check_grant("rd_grant", S_READ);
    check("read_cmd", sd_cmd, 4'h5);
    check("read_bank", sd_bank, 2'b01);
    rd_req = 1'b0;
    repeat (16) step();
    check("rd_17th_cycle", state, S_READ);
    pulse_end(S_READ);
    check("coincide_arbit", state, S_ARBIT);
    check("coincide_no_err", err_timeout, 1'b0);

    // 6. async reset during a write grant
    wr_req = 1'b1;
    step();
    check_grant("rst_grant", S_WRITE);
    wr_req = 1'b0;
    #2 s_rst_n = 1'b0;
    #1;
    check("async_state", state, S_IDLE);
    check("async_dq_oe", dq_oe, 1'b0);
    check("async_wr_en", wr_en, 1'b0);
    check("async_cmd", sd_cmd, 4'hA);
    step();
    s_rst_n = 1'b1;
    step();
    check("recover_arbit", state, S_ARBIT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
